// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register slave: frame layout, FSM states,
// and the write request passed from the frame decoder to the register bank.
package spi_pkg;

    localparam int   FRAME_BITS = 16;
    localparam int   ADDR_BITS  = 7;
    localparam logic RW_WRITE   = 1'b1;

    // Frame decoder states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_e;

    // Single-cycle write request into the register bank
    typedef struct packed {
        logic                 en;
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           data;
    } wr_req_t;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: one write port, flattened read-out of all registers, and an
// addressed read port that returns 0 for addresses beyond the bank.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         ena,
    input  wr_req_t                      wr,
    input  logic [ADDR_BITS-1:0]         rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [NUM_REGS*DATA_W-1:0]   regs
);

    logic [DATA_W-1:0] bank [NUM_REGS];

    // Storage: cleared on reset, one register written per committed request
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else if (ena && wr.en) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr.addr == ADDR_BITS'(i)) bank[i] <= wr.data;
        end
    end

    // Read mux: no match (out-of-range address) leaves the default 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == ADDR_BITS'(i)) rd_data = bank[i];
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs[g*DATA_W +: DATA_W] = bank[g];
        end
    endgenerate

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave. 16-bit MSB-first frames: R/W, 7-bit address,
// 8-bit data. Inputs arrive already synchronized to clk; edges are found by
// one more register stage here.
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       ena,
    input  logic                       sclk_s,
    input  logic                       cs_n_s,
    input  logic                       mosi_s,
    output logic                       miso,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_pulse,
    output logic [ADDR_BITS-1:0]       wr_addr
);

    logic                  sclk_q, cs_q;
    logic                  rise, fall, cs_start;
    spi_state_e            state, state_nx;
    logic [3:0]            bit_cnt, bit_cnt_nx;
    logic [FRAME_BITS-2:0] rx_shift, rx_shift_nx;
    logic [FRAME_BITS-1:0] rx_in;
    logic [7:0]            tx_shift, tx_shift_nx;
    logic [DATA_W-1:0]     rd_data;
    wr_req_t               wr;

    assign rise     = sclk_s & ~sclk_q;
    assign fall     = ~sclk_s & sclk_q;
    assign cs_start = ~cs_n_s & cs_q;

    // Shift register contents as they will be once the current mosi bit is
    // taken; on the 8th rise the low 7 bits are the address being read.
    assign rx_in = {rx_shift, mosi_s};

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_bank (
        .clk     (clk),
        .rstb    (rstb),
        .ena     (ena),
        .wr      (wr),
        .rd_addr (rx_in[ADDR_BITS-1:0]),
        .rd_data (rd_data),
        .regs    (regs)
    );

    // Next-state: frame sequencing, bit capture, read-data shifting, write commit
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        rx_shift_nx = rx_shift;
        tx_shift_nx = tx_shift;
        wr          = '0;
        if (cs_n_s) begin
            // CS high wins over everything, including a same-cycle rise
            state_nx    = IDLE;
            bit_cnt_nx  = '0;
            tx_shift_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_nx  = '0;
                    tx_shift_nx = '0;
                    if (cs_start) state_nx = ADDR;
                end
                ADDR: begin
                    if (rise) begin
                        rx_shift_nx = rx_in[FRAME_BITS-2:0];
                        bit_cnt_nx  = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_nx = DATA;
                            if (rx_in[7] != RW_WRITE) tx_shift_nx = rd_data;
                        end
                    end
                end
                DATA: begin
                    if (rise) begin
                        rx_shift_nx = rx_in[FRAME_BITS-2:0];
                        bit_cnt_nx  = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state_nx = DONE;
                            if (rx_in[15] == RW_WRITE && int'(rx_in[14:8]) < NUM_REGS) begin
                                wr.en   = 1'b1;
                                wr.addr = rx_in[14:8];
                                wr.data = rx_in[7:0];
                            end
                        end
                    end else if (fall && bit_cnt != 4'd8) begin
                        // The fall right after the address byte is where the
                        // master expects the data MSB to appear, so it must
                        // not shift; later falls move to the next bit.
                        tx_shift_nx = {tx_shift[6:0], 1'b0};
                    end
                end
                DONE: ;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State registers: reset first, then hold everything while ena is low
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
        end else if (ena) begin
            sclk_q   <= sclk_s;
            cs_q     <= cs_n_s;
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            rx_shift <= rx_shift_nx;
            tx_shift <= tx_shift_nx;
            wr_pulse <= wr.en;
            if (wr.en) wr_addr <= wr.addr;
        end
    end

    assign miso = (state == DATA) ? tx_shift[7] : 1'b0;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed frames from the requirement examples plus
// random frames, all checked every cycle against a frame-level register model.
module tb_spi_reg_slave;

    localparam int NR = 8;
    localparam int H  = 3;   // clk cycles per SCLK half period

    logic          clk = 1'b0;
    logic          rstb = 1'b0, ena = 1'b1;
    logic          sclk_s = 1'b0, cs_n_s = 1'b1, mosi_s = 1'b0;
    logic          miso, wr_pulse;
    logic [NR*8-1:0] regs;
    logic [6:0]    wr_addr;

    spi_reg_slave #(.NUM_REGS(NR), .DATA_W(8)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .sclk_s   (sclk_s),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s),
        .miso     (miso),
        .regs     (regs),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    // Model state: register contents, strobe and last write address
    logic [7:0]      m_regs [NR];
    logic            m_pulse = 1'b0;
    logic [6:0]      m_waddr = '0;
    logic [NR*8-1:0] m_flat;
    logic            chk_en = 1'b0, miso_chk = 1'b0, idle_chk = 1'b0, exp_miso = 1'b0;
    int              nvec = 0, nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NR; i++) m_flat[i*8 +: 8] = m_regs[i];
            check("regs", regs, m_flat);
            check("wr_pulse", 64'(wr_pulse), 64'(m_pulse));
            check("wr_addr", 64'(wr_addr), 64'(m_waddr));
            if (miso_chk)      check("miso_bit", 64'(miso), 64'(exp_miso));
            else if (idle_chk) check("miso_idle", 64'(miso), 64'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI frame of nbits clocks. rst_at: bit index at which to pulse reset
    // (-1 none). ena_at: bit index whose high phase is stalled by ena=0.
    task automatic frame(input logic [15:0] f, input int nbits, input int rst_at,
                         input int ena_at, output logic [7:0] rd_byte);
        logic       rw;
        logic [6:0] a;
        logic [7:0] rexp;
        bit         killed;
        rw = f[15];
        a = f[14:8];
        killed = 0;
        rexp = (int'(a) < NR) ? m_regs[int'(a)] : 8'h00;
        rd_byte = '0;
        idle_chk = 1'b0;
        sclk_s = 1'b0;
        cs_n_s = 1'b0;
        cyc(2);
        for (int i = 0; i < nbits; i++) begin
            mosi_s = (i < 16) ? f[15-i] : 1'($urandom);
            sclk_s = 1'b0;
            cyc(H);
            if (i >= 8 && i < 16 && !rw && !killed) begin
                exp_miso = rexp[15-i];
                miso_chk = 1'b1;
                rd_byte[15-i] = miso;
            end
            cyc(1);
            miso_chk = 1'b0;
            if (i == rst_at) begin
                rstb = 1'b0;
                cyc(1);
                for (int k = 0; k < NR; k++) m_regs[k] = '0;
                m_pulse = 1'b0;
                m_waddr = '0;
                idle_chk = 1'b1;
                cyc(1);
                idle_chk = 1'b0;
                rstb = 1'b1;
                killed = 1;
            end
            sclk_s = 1'b1;
            cyc(1);
            if (i == 15 && !killed && rw && int'(a) < NR) begin
                m_regs[int'(a)] = f[7:0];
                m_pulse = 1'b1;
                m_waddr = a;
                cyc(1);
                m_pulse = 1'b0;
                cyc(H - 2);
            end else if (i == ena_at) begin
                ena = 1'b0;
                cyc(5);
                ena = 1'b1;
                cyc(H - 1);
            end else begin
                cyc(H - 1);
            end
        end
        sclk_s = 1'b0;
        cyc(2);
        cs_n_s = 1'b1;
        cyc(2);
        idle_chk = 1'b1;
        cyc(2);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] rb;
        logic [15:0] f;
        int nb;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        rstb = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        idle_chk = 1'b1;
        cyc(3);
        rstb = 1'b1;
        cyc(2);

        // Write 0x5A to reg 3, then read it back
        frame(16'h835A, 16, -1, -1, rb);
        check("lit_w3_reg", 64'(regs[31:24]), 64'h5A);
        check("lit_w3_model", 64'(m_regs[3]), 64'h5A);
        check("lit_w3_addr", 64'(wr_addr), 64'd3);
        frame(16'h0300, 16, -1, -1, rb);
        check("lit_rd3", 64'(rb), 64'h5A);

        // Aborted write after 10 bits leaves reg 7 alone
        frame(16'h8711, 16, -1, -1, rb);
        frame(16'h87FF, 10, -1, -1, rb);
        check("lit_abort_r7", 64'(regs[63:56]), 64'h11);
        check("lit_abort_addr", 64'(wr_addr), 64'd7);

        // Out-of-range write ignored, out-of-range read returns 0
        frame(16'h90AA, 16, -1, -1, rb);
        frame(16'h1000, 16, -1, -1, rb);
        check("lit_oor_rd", 64'(rb), 64'h00);
        check("lit_oor_addr", 64'(wr_addr), 64'd7);

        // Reset mid-frame wipes the bank; next full write lands alone
        frame(16'h8144, 16, 12, -1, rb);
        frame(16'h8122, 16, -1, -1, rb);
        check("lit_rst_bank", regs, 64'h0000_0000_0000_2200);

        // 20 SCLK pulses and an ena stall mid-frame
        frame(16'h8266, 20, -1, 5, rb);
        check("lit_extra_r2", 64'(regs[23:16]), 64'h66);
        check("lit_extra_addr", 64'(wr_addr), 64'd2);

        // Random frames: mixed reads/writes, in- and out-of-range, some cut short
        for (int n = 0; n < 40; n++) begin
            f[15]   = 1'($urandom);
            f[14:8] = 7'($urandom_range(0, 11));
            f[7:0]  = 8'($urandom);
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15))
                                             : int'($urandom_range(16, 19));
            frame(f, nb, -1, -1, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
